// File: rtl/hazard_stall_unit_if.sv
// Bundle between the ID-stage hazard unit and the pipeline around it:
// hazard/handshake inputs and the pipeline control and counter outputs.
interface hazard_stall_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_RS1_i;
    logic [4:0]       ID_RS2_i;
    logic             ID_Branch_i;
    logic             ID_BranchTaken_i;
    logic             EX_MemRead_i;
    logic             EX_RegWrite_i;
    logic [4:0]       EX_RD_i;
    logic             MEM_MemRead_i;
    logic [4:0]       MEM_RD_i;
    logic             MemReq_i;
    logic             MemAck_i;
    logic             NoOp_o;
    logic             Stall_o;
    logic             Flush_o;
    logic             Freeze_o;
    logic             Error_o;
    logic [CNT_W-1:0] StallCnt_o;
    logic [CNT_W-1:0] FreezeCnt_o;
    logic [CNT_W-1:0] FlushCnt_o;

    modport master (
        output ID_RS1_i, ID_RS2_i, ID_Branch_i, ID_BranchTaken_i,
        output EX_MemRead_i, EX_RegWrite_i, EX_RD_i,
        output MEM_MemRead_i, MEM_RD_i, MemReq_i, MemAck_i,
        input  NoOp_o, Stall_o, Flush_o, Freeze_o, Error_o,
        input  StallCnt_o, FreezeCnt_o, FlushCnt_o
    );

    modport slave (
        input  ID_RS1_i, ID_RS2_i, ID_Branch_i, ID_BranchTaken_i,
        input  EX_MemRead_i, EX_RegWrite_i, EX_RD_i,
        input  MEM_MemRead_i, MEM_RD_i, MemReq_i, MemAck_i,
        output NoOp_o, Stall_o, Flush_o, Freeze_o, Error_o,
        output StallCnt_o, FreezeCnt_o, FlushCnt_o
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detection, branch flush and memory-freeze control with
// a timeout watchdog and saturating performance counters.
module hazard_stall_unit #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hazard_stall_unit_if.slave bus
);
    localparam int WW = $clog2(TIMEOUT) + 1;

    typedef enum logic {
        S_RUN,
        S_FREEZE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WW-1:0]    r_wait;
    logic [WW-1:0]    w_wait_nxt;
    logic             r_error;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_freeze_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_lu;
    logic w_be;
    logic w_bm;
    logic w_haz;
    logic w_noop;
    logic w_stall;
    logic w_flush;
    logic w_freeze;

    function automatic logic f_match(
        input logic [4:0] r,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return (r != 5'd0) && ((r == rs1) || (r == rs2));
    endfunction

    always_comb begin
        w_lu  = bus.EX_MemRead_i
              & f_match(bus.EX_RD_i, bus.ID_RS1_i, bus.ID_RS2_i);
        w_be  = bus.ID_Branch_i & bus.EX_RegWrite_i
              & f_match(bus.EX_RD_i, bus.ID_RS1_i, bus.ID_RS2_i);
        w_bm  = bus.ID_Branch_i & bus.MEM_MemRead_i
              & f_match(bus.MEM_RD_i, bus.ID_RS1_i, bus.ID_RS2_i);
        w_haz = w_lu | w_be | w_bm;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_freeze    = 1'b0;
        unique case (r_state)
            S_RUN: begin
                if (bus.MemReq_i && !bus.MemAck_i) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = S_FREEZE;
                    w_wait_nxt  = WW'(1);
                end
            end
            S_FREEZE: begin
                if (bus.MemAck_i) begin
                    w_state_nxt = S_RUN;
                    w_wait_nxt  = '0;
                end else begin
                    w_freeze = 1'b1;
                    if (r_wait != WW'(TIMEOUT)) begin
                        w_wait_nxt = r_wait + WW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_wait_nxt  = '0;
            end
        endcase
        if (rst_i) begin
            w_freeze = 1'b0;
        end
    end

    // Freeze masks hazards; held inputs are re-evaluated once it lifts.
    always_comb begin
        w_noop  = 1'b0;
        w_stall = 1'b0;
        w_flush = 1'b0;
        if (!rst_i && !w_freeze) begin
            if (w_haz) begin
                w_noop  = 1'b1;
                w_stall = 1'b1;
            end else begin
                w_flush = bus.ID_Branch_i & bus.ID_BranchTaken_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_RUN;
            r_wait  <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            if (w_wait_nxt == WW'(TIMEOUT)) begin
                r_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt  <= '0;
            r_freeze_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_noop && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_freeze && (r_freeze_cnt != '1)) begin
                r_freeze_cnt <= r_freeze_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.NoOp_o      = w_noop;
    assign bus.Stall_o     = w_stall;
    assign bus.Flush_o     = w_flush;
    assign bus.Freeze_o    = w_freeze;
    assign bus.Error_o     = r_error;
    assign bus.StallCnt_o  = r_stall_cnt;
    assign bus.FreezeCnt_o = r_freeze_cnt;
    assign bus.FlushCnt_o  = r_flush_cnt;
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer side of the decoder's NoOp_i interface: detects data hazards in ID, inserts bubbles via NoOp_o, holds PC and IF/ID via Stall_o, and flushes IF/ID on a taken branch.
- Freezes the whole pipeline while a multi-cycle data-memory access is outstanding, using a req/ack handshake with a timeout watchdog.
- Keeps saturating performance counters.
- Sits in the ID stage beside the decoder and drives NoOp_i, PC write enable, IF/ID write enable, IF/ID flush and the global pipeline enable.

Parameters:
CNT_W, 32, width of each performance counter.
TIMEOUT, 1024, freeze cycles before Error_o is raised; must be ≥2.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
ID_RS1_i  in  5  rs1 of instruction in ID
ID_RS2_i  in  5  rs2 of instruction in ID
ID_Branch_i  in  1  ID instruction is beq
ID_BranchTaken_i  in  1  beq comparison equal, resolved in ID
EX_MemRead_i  in  1  ID/EX MemRead
EX_RegWrite_i  in  1  ID/EX RegWrite
EX_RD_i  in  5  ID/EX rd
MEM_MemRead_i  in  1  EX/MEM MemRead
MEM_RD_i  in  5  EX/MEM rd
MemReq_i  in  1  MEM-stage access pending (level)
MemAck_i  in  1  access completes this cycle (pulse)
NoOp_o  out  1  to decoder: zero control signals into ID/EX
Stall_o  out  1  hold PC and IF/ID
Flush_o  out  1  clear IF/ID
Freeze_o  out  1  hold all pipeline registers
Error_o  out  1  sticky memory-timeout flag
StallCnt_o  out  CNT_W  bubble cycles
FreezeCnt_o  out  CNT_W  freeze cycles
FlushCnt_o  out  CNT_W  flush cycles

Behaviour:
- Single clock clk_i; reset rst_i is synchronous and active-high.
- Reset:
  - state=RUN; wait counter=0; Error_o=0; all counters=0.
  - While rst_i=1, NoOp_o=Stall_o=Flush_o=Freeze_o=0 regardless of inputs.
- Match definition: mX(r) = (r!=0) & ((r==ID_RS1_i)|(r==ID_RS2_i)). x0 never matches.
- Hazard terms (combinational):
  - LU = EX_MemRead_i & mX(EX_RD_i): load-use, 1 bubble.
  - BE = ID_Branch_i & EX_RegWrite_i & mX(EX_RD_i): branch needs an EX result. This covers a load in EX.
  - BM = ID_Branch_i & MEM_MemRead_i & mX(MEM_RD_i): branch needs load data still in MEM.
  - A load followed directly by a beq therefore gets 2 bubbles (BE, then BM).
  - H = LU|BE|BM.
- FSM, two states; wait counter is log2(TIMEOUT)+1 bits:
  - RUN:
    - MemReq_i & !MemAck_i → FREEZE; Freeze_o=1 this cycle; wait counter=1.
    - MemReq_i & MemAck_i (single-cycle hit) → stay RUN, no freeze.
  - FREEZE:
    - Freeze_o=1 while !MemAck_i; wait counter increments, saturating at TIMEOUT.
    - MemAck_i → Freeze_o=0 this cycle, pipeline advances, → RUN.
    - Wait counter reaching TIMEOUT sets Error_o. Error_o stays 1 until reset.
    - The FSM keeps waiting for MemAck_i; no abort.
  - MemAck_i while in RUN with MemReq_i=0 is ignored.
- Outputs (Mealy on inputs + state), priority Freeze > hazard > flush:
  - Freeze_o=1 forces NoOp_o=Stall_o=Flush_o=0. The hazard is re-evaluated after release on the held, stable inputs.
  - Else H=1 → NoOp_o=1, Stall_o=1, Flush_o=0. A taken branch with an operand hazard is not flushed until its stall clears.
  - Else Flush_o = ID_Branch_i & ID_BranchTaken_i.
- Counters:
  - Each increments by 1 on every non-reset cycle its output is 1.
  - Each saturates at 2^CNT_W−1; no wrap.
  - Counters are registered, updated at the clock edge.
- Reset mid-freeze: returns to RUN next edge. A MemAck_i arriving the same cycle as rst_i is discarded.

Test Plan:
- Reset with MemReq_i=1, EX_MemRead_i=1 and matching rd held → all control outputs 0 during reset; counters 0 and state RUN after release.
- lw x5 in EX (EX_MemRead_i=1, EX_RD_i=5), ID_RS2_i=5 → NoOp_o=Stall_o=1 for exactly 1 cycle; StallCnt_o=1. The same case with EX_RD_i=0 and ID_RS1_i=0 → no stall.
- lw x7 followed by beq using x7, taken → BE cycle, then BM cycle (2 bubbles, Flush_o=0), then Flush_o=1 one cycle; StallCnt_o=2, FlushCnt_o=1.
- MemReq_i=1, MemAck_i after 5 cycles while LU holds → Freeze_o=1 for 5 cycles with NoOp_o=0; ack cycle Freeze_o=0 and NoOp_o=1; FreezeCnt_o=5.
- TIMEOUT=4, MemReq_i=1, no ack → Error_o rises after 4 freeze cycles and stays 1 after a later ack; cleared only by rst_i.
- CNT_W=3, continuous load-use stalls for 10 cycles → StallCnt_o saturates at 7.
